// File: rtl/cpu_pkg.sv
// Shared CPU slice definitions: default datapath widths, the architectural zero register,
// and the per-cycle action of the ID/EX operand stage.
package cpu_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_SEL_WIDTH  = 5;
    localparam int unsigned DEF_CTRL_WIDTH = 8;

    localparam logic [DEF_SEL_WIDTH-1:0] ZERO_REG = '0;

    // Priority-ordered action taken by the stage register on the next clock edge.
    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_FLUSH,
        ACT_CAPTURE,
        ACT_DRAIN,
        ACT_HOLD
    } stage_action_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-execute boundary of the operand stage: upstream instruction handshake and
// downstream resolved-operand handshake. The stage uses slave, its environment uses master.
interface id_ex_operand_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 5,
    parameter int unsigned CTRL_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_WIDTH-1:0]  in_rs;
    logic [SEL_WIDTH-1:0]  in_rt;
    logic [SEL_WIDTH-1:0]  in_rd;
    logic [CTRL_WIDTH-1:0] in_ctrl;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_op_a;
    logic [DATA_WIDTH-1:0] out_op_b;
    logic [SEL_WIDTH-1:0]  out_rd;
    logic [CTRL_WIDTH-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_ctrl, out_ready,
        output in_ready, out_valid, out_op_a, out_op_b, out_rd, out_ctrl
    );

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_ctrl, out_ready,
        input  in_ready, out_valid, out_op_a, out_op_b, out_rd, out_ctrl
    );

endinterface

// File: rtl/operand_bypass.sv
// Resolves one source operand from register-file data with same-cycle writeback bypass.
// Build option ZERO_REG_EN: the zero register always reads as 0 and is never bypassed.
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  wb_we,
    input  logic [SEL_WIDTH-1:0]  wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (wb_we && (wb_addr == sel)) begin
            operand = wb_data;
        end
`ifdef ZERO_REG_EN
        if (sel == SEL_WIDTH'(ZERO_REG)) begin
            operand = '0;
        end
`endif
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand resolution, writeback bypass and snooping while held.
// Build option ZERO_REG_EN: register 0 is hardwired to zero (no bypass, no snoop).
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
    parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_operand_stage_if.slave  pipe,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_1,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_2,
    input  logic [DATA_WIDTH-1:0] rf_read_data_1,
    input  logic [DATA_WIDTH-1:0] rf_read_data_2,
    input  logic                  wb_RegWrite,
    input  logic [SEL_WIDTH-1:0]  wb_write_address,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic                  flush
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [SEL_WIDTH-1:0]  rd_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [SEL_WIDTH-1:0]  held_rs_q;
    logic [SEL_WIDTH-1:0]  held_rt_q;

    logic [DATA_WIDTH-1:0] op_a_res;
    logic [DATA_WIDTH-1:0] op_b_res;
    logic                  in_ready;
    logic                  snoop_a;
    logic                  snoop_b;
    stage_action_e         action;

    operand_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_bypass_a (
        .sel     (pipe.in_rs),
        .rf_data (rf_read_data_1),
        .wb_we   (wb_RegWrite),
        .wb_addr (wb_write_address),
        .wb_data (wb_write_data),
        .operand (op_a_res)
    );

    operand_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_bypass_b (
        .sel     (pipe.in_rt),
        .rf_data (rf_read_data_2),
        .wb_we   (wb_RegWrite),
        .wb_addr (wb_write_address),
        .wb_data (wb_write_data),
        .operand (op_b_res)
    );

    always_comb begin
        rf_read_sel_1  = pipe.in_rs;
        rf_read_sel_2  = pipe.in_rt;
        in_ready       = (!valid_q || pipe.out_ready) && !flush;
        pipe.in_ready  = in_ready;
        pipe.out_valid = valid_q;
        pipe.out_op_a  = op_a_q;
        pipe.out_op_b  = op_b_q;
        pipe.out_rd    = rd_q;
        pipe.out_ctrl  = ctrl_q;
    end

    // A held operand tracks later writes to its source register so it never goes stale.
    always_comb begin
        snoop_a = wb_RegWrite && (wb_write_address == held_rs_q);
        snoop_b = wb_RegWrite && (wb_write_address == held_rt_q);
`ifdef ZERO_REG_EN
        if (held_rs_q == SEL_WIDTH'(ZERO_REG)) snoop_a = 1'b0;
        if (held_rt_q == SEL_WIDTH'(ZERO_REG)) snoop_b = 1'b0;
`endif
    end

    always_comb begin
        action = ACT_IDLE;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (pipe.in_valid && in_ready) begin
            action = ACT_CAPTURE;
        end else if (valid_q && pipe.out_ready) begin
            action = ACT_DRAIN;
        end else if (valid_q) begin
            action = ACT_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            held_rs_q <= '0;
            held_rt_q <= '0;
        end else begin
            unique case (action)
                ACT_FLUSH: begin
                    valid_q <= 1'b0;
                end
                ACT_CAPTURE: begin
                    valid_q   <= 1'b1;
                    op_a_q    <= op_a_res;
                    op_b_q    <= op_b_res;
                    rd_q      <= pipe.in_rd;
                    ctrl_q    <= pipe.in_ctrl;
                    held_rs_q <= pipe.in_rs;
                    held_rt_q <= pipe.in_rt;
                end
                ACT_DRAIN: begin
                    valid_q <= 1'b0;
                end
                ACT_HOLD: begin
                    if (snoop_a) op_a_q <= wb_write_data;
                    if (snoop_b) op_b_q <= wb_write_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed, table-driven bench for id_ex_operand_stage; expectations follow ZERO_REG_EN.
module tb_id_ex_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned CW = 8;

`ifdef ZERO_REG_EN
    localparam logic [31:0] R0_BYP   = 32'h0;
    localparam logic [31:0] R0_SNOOP = 32'h0;
`else
    localparam logic [31:0] R0_BYP   = 32'h5;
    localparam logic [31:0] R0_SNOOP = 32'h9;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] rf_read_sel_1, rf_read_sel_2;
    logic [DW-1:0] rf_read_data_1, rf_read_data_2;
    logic          wb_RegWrite;
    logic [SW-1:0] wb_write_address;
    logic [DW-1:0] wb_write_data;
    logic          flush;

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .CTRL_WIDTH(CW)) pipe ();

    id_ex_operand_stage #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .CTRL_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pipe             (pipe),
        .rf_read_sel_1    (rf_read_sel_1),
        .rf_read_sel_2    (rf_read_sel_2),
        .rf_read_data_1   (rf_read_data_1),
        .rf_read_data_2   (rf_read_data_2),
        .wb_RegWrite      (wb_RegWrite),
        .wb_write_address (wb_write_address),
        .wb_write_data    (wb_write_data),
        .flush            (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
        logic [31:0] rf1, rf2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl, ordy;
        logic        e_irdy, e_v, chk_d;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_rd;
        logic [7:0]  e_ctrl;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [7:0] ctrl, input logic [31:0] rf1, input logic [31:0] rf2,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic fl, input logic ordy, input logic e_irdy, input logic e_v, input logic chk_d,
        input logic [31:0] e_a, input logic [31:0] e_b, input logic [4:0] e_rd, input logic [7:0] e_ctrl);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.ctrl = ctrl; r.rf1 = rf1; r.rf2 = rf2;
        r.we = we; r.wa = wa; r.wd = wd; r.fl = fl; r.ordy = ordy;
        r.e_irdy = e_irdy; r.e_v = e_v; r.chk_d = chk_d;
        r.e_a = e_a; r.e_b = e_b; r.e_rd = e_rd; r.e_ctrl = e_ctrl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        pipe.in_valid    = t.v;
        pipe.in_rs       = t.rs;
        pipe.in_rt       = t.rt;
        pipe.in_rd       = t.rd;
        pipe.in_ctrl     = t.ctrl;
        rf_read_data_1   = t.rf1;
        rf_read_data_2   = t.rf2;
        wb_RegWrite      = t.we;
        wb_write_address = t.wa;
        wb_write_data    = t.wd;
        flush            = t.fl;
        pipe.out_ready   = t.ordy;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 0, 8'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h0));
    endtask

    vec_t vecs[15];

    initial begin
        //            v rs rt rd ctrl   rf1     rf2     we wa wd        fl or  irdy ev cd e_a        e_b        rd ctrl
        vecs[0]  = mk(1, 3, 4, 7, 8'hA1, 32'h11, 32'h22, 0, 0, 32'h0,    0, 1,  1, 1, 1, 32'h11,    32'h22,    7, 8'hA1);
        vecs[1]  = mk(1, 3, 4, 8, 8'hB2, 32'h11, 32'h22, 1, 3, 32'hDEAD, 0, 1,  1, 1, 1, 32'hDEAD,  32'h22,    8, 8'hB2);
        vecs[2]  = mk(1, 5, 5, 9, 8'hC3, 32'h55, 32'h55, 0, 0, 32'h0,    0, 1,  1, 1, 1, 32'h55,    32'h55,    9, 8'hC3);
        vecs[3]  = mk(1, 1, 2, 2, 8'hEE, 32'h1,  32'h2,  1, 5, 32'hBEEF, 0, 0,  0, 1, 1, 32'hBEEF,  32'hBEEF,  9, 8'hC3);
        vecs[4]  = mk(0, 0, 0, 0, 8'h0,  32'h0,  32'h0,  1, 6, 32'h1234, 0, 0,  0, 1, 1, 32'hBEEF,  32'hBEEF,  9, 8'hC3);
        vecs[5]  = mk(1, 2, 2, 3, 8'h12, 32'h9,  32'h9,  0, 0, 32'h0,    0, 0,  0, 1, 1, 32'hBEEF,  32'hBEEF,  9, 8'hC3);
        vecs[6]  = mk(0, 0, 0, 0, 8'h0,  32'h0,  32'h0,  0, 0, 32'h0,    0, 1,  1, 0, 0, 32'h0,     32'h0,     0, 8'h0);
        vecs[7]  = mk(1, 1, 2, 3, 8'h44, 32'h100,32'h200,0, 0, 32'h0,    0, 0,  1, 1, 1, 32'h100,   32'h200,   3, 8'h44);
        vecs[8]  = mk(1, 7, 7, 7, 8'h77, 32'h7,  32'h7,  1, 1, 32'hFFFF, 1, 0,  0, 0, 0, 32'h0,     32'h0,     0, 8'h0);
        vecs[9]  = mk(1, 1, 2, 4, 8'h55, 32'h100,32'h200,0, 0, 32'h0,    0, 0,  1, 1, 1, 32'h100,   32'h200,   4, 8'h55);
        vecs[10] = mk(0, 0, 0, 0, 8'h0,  32'h0,  32'h0,  1, 2, 32'h2222, 0, 0,  0, 1, 1, 32'h100,   32'h2222,  4, 8'h55);
        vecs[11] = mk(1, 0, 4, 6, 8'h66, 32'h77, 32'h44, 1, 0, 32'h5,    0, 1,  1, 1, 1, R0_BYP,    32'h44,    6, 8'h66);
        vecs[12] = mk(0, 0, 0, 0, 8'h0,  32'h0,  32'h0,  1, 0, 32'h9,    0, 0,  0, 1, 1, R0_SNOOP,  32'h44,    6, 8'h66);
        vecs[13] = mk(0, 0, 0, 0, 8'h0,  32'h0,  32'h0,  1, 0, 32'h3,    1, 0,  0, 0, 0, 32'h0,     32'h0,     0, 8'h0);
        vecs[14] = mk(0, 0, 0, 0, 8'h0,  32'h0,  32'h0,  0, 0, 32'h0,    0, 0,  1, 0, 0, 32'h0,     32'h0,     0, 8'h0);

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(pipe.out_valid), 32'h0);
        chk("reset op_a", pipe.out_op_a, 32'h0);
        chk("reset op_b", pipe.out_op_b, 32'h0);
        chk("reset rd", 32'(pipe.out_rd), 32'h0);
        chk("reset ctrl", 32'(pipe.out_ctrl), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", 32'(pipe.in_ready), 32'h1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(pipe.in_ready), 32'(vecs[i].e_irdy));
            chk($sformatf("v%0d rf_sel_1", i), 32'(rf_read_sel_1), 32'(vecs[i].rs));
            chk($sformatf("v%0d rf_sel_2", i), 32'(rf_read_sel_2), 32'(vecs[i].rt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(pipe.out_valid), 32'(vecs[i].e_v));
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d op_a", i), pipe.out_op_a, vecs[i].e_a);
                chk($sformatf("v%0d op_b", i), pipe.out_op_b, vecs[i].e_b);
                chk($sformatf("v%0d rd", i), 32'(pipe.out_rd), 32'(vecs[i].e_rd));
                chk($sformatf("v%0d ctrl", i), 32'(pipe.out_ctrl), 32'(vecs[i].e_ctrl));
            end
        end

        // Back-to-back stream: one result per cycle, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive(mk(1, 5'(i), 5'(i + 8), 5'(i), 8'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i),
                     0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 8'h0));
            #1;
            chk($sformatf("b2b%0d in_ready", i), 32'(pipe.in_ready), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d out_valid", i), 32'(pipe.out_valid), 32'h1);
            chk($sformatf("b2b%0d op_a", i), pipe.out_op_a, 32'h1000 + 32'(i));
            chk($sformatf("b2b%0d op_b", i), pipe.out_op_b, 32'h2000 + 32'(i));
            chk($sformatf("b2b%0d rd", i), 32'(pipe.out_rd), 32'(i));
        end

        // Reset mid-stream with in_valid still high.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("stream reset out_valid", 32'(pipe.out_valid), 32'h0);
        chk("stream reset op_a", pipe.out_op_a, 32'h0);
        chk("stream reset rd", 32'(pipe.out_rd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        #1;
        chk("stream release in_ready", 32'(pipe.in_ready), 32'h1);

        // Capture, hold, then reset mid-hold.
        drive(mk(1, 3, 4, 2, 8'h21, 32'hAB, 32'hCD, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 8'h0));
        @(posedge clk);
        @(negedge clk);
        pipe.in_valid = 1'b0;
        #1;
        chk("hold in_ready", 32'(pipe.in_ready), 32'h0);
        chk("hold op_a", pipe.out_op_a, 32'hAB);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("hold reset out_valid", 32'(pipe.out_valid), 32'h0);
        chk("hold reset op_b", pipe.out_op_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("hold release in_ready", 32'(pipe.in_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, operand/write-data width.
REQ-002 SHALL have parameter SEL_WIDTH, 5, register select width.
REQ-003 SHALL have parameter CTRL_WIDTH, 8, opaque decoded-control width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  decoded instruction present.
REQ-007 in_ready  out  1  stage accepts instruction this cycle.
REQ-008 in_rs, in_rt  in  SEL_WIDTH each  source register selects.
REQ-009 in_rd  in  SEL_WIDTH  destination select, passed through.
REQ-010 in_ctrl  in  CTRL_WIDTH  control bits, passed through.
REQ-011 rf_read_sel_1, rf_read_sel_2  out  SEL_WIDTH each  register file read selects.
REQ-012 rf_read_data_1, rf_read_data_2  in  DATA_WIDTH each  combinational register file read data.
REQ-013 wb_RegWrite  in  1  writeback write enable (same signal driving the register file).
REQ-014 wb_write_address  in  SEL_WIDTH  writeback destination.
REQ-015 wb_write_data  in  DATA_WIDTH  writeback data.
REQ-016 flush  in  1  discard held and incoming instruction.
REQ-017 out_valid  out  1  held instruction valid.
REQ-018 out_ready  in  1  execute stage accepts held instruction.
REQ-019 out_op_a, out_op_b  out  DATA_WIDTH each  resolved operands.
REQ-020 out_rd, out_ctrl  out  SEL_WIDTH / CTRL_WIDTH  held pass-through fields.

Function
REQ-021 rf_read_sel_1/2 SHALL equal in_rs/in_rt combinationally.
REQ-022 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-023 Capture: on in_valid && in_ready, register in_rd, in_ctrl and resolved operands; out_valid=1 next cycle; latency exactly 1 cycle.
REQ-024 Operand resolve: if wb_RegWrite && wb_write_address==sel, operand = wb_write_data (bypass of same-cycle write), else rf_read_data.
REQ-025 Hold: while out_valid && !out_ready, outputs SHALL stay stable except snoop update (REQ-026).
REQ-026 Snoop: while holding, a wb write to the held rs (rt) address SHALL overwrite out_op_a (out_op_b) next cycle; both if rs==rt.
REQ-027 Held rs/rt addresses SHALL be stored internally for snooping.
REQ-028 Drain: out_valid && out_ready && !in_valid -> out_valid=0 next cycle.
REQ-029 Back-to-back: out_ready && in_valid each cycle -> one instruction per cycle, no bubbles.
REQ-030 flush SHALL clear out_valid next cycle, overriding capture and hold; data regs may keep stale values.
REQ-031 Flush and wb write same cycle: flush wins; wb write is not snooped.

Reset
REQ-032 rst_n low at posedge clk: out_valid=0, out_op_a/b=0, out_rd=0, out_ctrl=0, held selects=0.
REQ-033 Reset mid-hold SHALL drop the held instruction; in_ready=1 first cycle after reset release.

Configuration
REQ-034 Macro ZERO_REG_EN defined: select 0 operand SHALL resolve to 0 regardless of rf data or wb, and snoop/bypass of address 0 suppressed.
REQ-035 ZERO_REG_EN undefined: address 0 treated as ordinary register, bypass and snoop apply.

Structure
REQ-036 Shared package cpu_pkg SHALL hold DATA_WIDTH, SEL_WIDTH, CTRL_WIDTH defaults and zero-register constant.
REQ-037 Sub-module operand_bypass (sel, rf_data, wb fields -> operand, honours ZERO_REG_EN) SHALL be instantiated twice.

Verification
REQ-038 Reset then in_valid, rs=3 (rf=0x11), rt=4 (rf=0x22), no wb -> next cycle out_valid=1, op_a=0x11, op_b=0x22.
REQ-039 Capture with wb writing 0xDEAD to r3 same cycle, rf still 0x11 -> op_a=0xDEAD.
REQ-040 Hold (out_ready=0) rs=rt=5, wb writes 0xBEEF to r5 -> next cycle op_a=op_b=0xBEEF, in_ready=0.
REQ-041 flush with in_valid=1 and held valid -> out_valid=0 next cycle, in_ready=0 during flush cycle.
REQ-042 ZERO_REG_EN defined, rs=0, wb writes 0x5 to r0 -> op_a=0; undefined -> op_a=0x5.
REQ-043 Continuous in_valid/out_ready for 8 cycles -> 8 consecutive outputs, no bubble; rst_n low mid-stream -> out_valid=0 next cycle.
